// File: rtl/servo_slew_scheduler.sv
// Round-robin slew limiter for twelve servo position bytes: once per tick period it walks
// a shared compare/step datapath over servos 0..11, moving each by at most STEP toward a snapshot.
module servo_slew_scheduler #(
  parameter logic [15:0] TICK_DIV = 16'd50000,
  parameter logic [7:0]  STEP     = 8'd2,
  parameter logic [7:0]  INIT_POS = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] iTarget,
  input  logic        iHold,
  output logic [95:0] oPos,
  output logic        oBusy,
  output logic        oSweep_Done,
  output logic        oSettled
);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [3:0]  idx_q, idx_d;
  logic [95:0] pos_q, pos_d;
  logic [95:0] snap_q, snap_d;
  logic        changed_q, changed_d;
  logic        settled_q, settled_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [6:0]  bit_base;
  logic [7:0]  cur, tgt, gap, next_pos;
  logic        up;

  // Shared step datapath for the servo currently selected by idx_q.
  always_comb begin
    bit_base = {idx_q, 3'b000};
    cur      = pos_q[bit_base +: 8];
    tgt      = snap_q[bit_base +: 8];
    up       = tgt > cur;
    gap      = up ? (tgt - cur) : (cur - tgt);
    if (gap <= STEP) begin
      next_pos = tgt;
    end else if (up) begin
      next_pos = cur + STEP;
    end else begin
      next_pos = cur - STEP;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    snap_d    = snap_q;
    changed_d = changed_q;
    settled_d = settled_q;
    unique case (state_q)
      StIdle: begin
        if (!iHold) begin
          if (tick_q == TICK_DIV - 16'd1) begin
            tick_d  = '0;
            snap_d  = iTarget;
            state_d = StSweep;
          end else begin
            tick_d = tick_q + 16'd1;
          end
        end
      end
      StSweep: begin
        pos_d[bit_base +: 8] = next_pos;
        if (next_pos != cur) begin
          changed_d = 1'b1;
        end
        if (idx_q == 4'd11) begin
          idx_d     = '0;
          state_d   = StDone;
          // Settled lands on the same edge that raises the done pulse.
          settled_d = ~changed_d;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StDone: begin
        changed_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StSweep);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      idx_q     <= '0;
      pos_q     <= {12{INIT_POS}};
      snap_q    <= {12{INIT_POS}};
      changed_q <= 1'b0;
      settled_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      snap_q    <= snap_d;
      changed_q <= changed_d;
      settled_q <= settled_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign oPos        = pos_q;
  assign oBusy       = busy_q;
  assign oSweep_Done = done_q;
  assign oSettled    = settled_q;

endmodule

// File: tb/tb_servo_slew_scheduler.sv
// Bench for servo_slew_scheduler: a period-level model checked every cycle against one
// instance, plus directed literal checks on three parameterisations.
module tb_servo_slew_scheduler;

  localparam int TD     = 4;
  localparam int STEP_A = 10;
  localparam int INIT_A = 0;

  logic        clk    = 1'b0;
  logic        rst_a  = 1'b0;
  logic        rst_bc = 1'b0;
  logic        hold_a = 1'b0;
  logic [95:0] tgt_a, tgt_b, tgt_c;
  logic [95:0] pos_a, pos_b, pos_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        settled_a, settled_b, settled_c;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  servo_slew_scheduler #(.TICK_DIV(16'd4), .STEP(8'd10), .INIT_POS(8'd0)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .iTarget(tgt_a), .iHold(hold_a), .oPos(pos_a),
    .oBusy(busy_a), .oSweep_Done(done_a), .oSettled(settled_a)
  );

  servo_slew_scheduler #(.TICK_DIV(16'd4), .STEP(8'd10), .INIT_POS(8'd128)) u_dut_b (
    .clk(clk), .rst_n(rst_bc), .iTarget(tgt_b), .iHold(1'b0), .oPos(pos_b),
    .oBusy(busy_b), .oSweep_Done(done_b), .oSettled(settled_b)
  );

  servo_slew_scheduler #(.TICK_DIV(16'd4), .STEP(8'd255), .INIT_POS(8'd100)) u_dut_c (
    .clk(clk), .rst_n(rst_bc), .iTarget(tgt_c), .iHold(1'b0), .oPos(pos_c),
    .oBusy(busy_c), .oSweep_Done(done_c), .oSettled(settled_c)
  );

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Model of instance A: a period position counter plus per-servo integer positions.
  int m_pos[12];
  int m_snap[12];
  int m_phase;
  bit m_changed;
  bit m_settled;

  task automatic model_reset();
    for (int k = 0; k < 12; k++) begin
      m_pos[k]  = INIT_A;
      m_snap[k] = INIT_A;
    end
    m_phase   = 0;
    m_changed = 0;
    m_settled = 0;
  endtask

  task automatic model_step();
    int k, c, t, d;
    if (m_phase < TD) begin
      if (!hold_a) begin
        if (m_phase == TD - 1) begin
          for (int j = 0; j < 12; j++) m_snap[j] = int'(tgt_a[8*j +: 8]);
        end
        m_phase++;
      end
    end else if (m_phase < TD + 12) begin
      k = m_phase - TD;
      c = m_pos[k];
      t = m_snap[k];
      d = (t > c) ? t - c : c - t;
      if (d > STEP_A) d = STEP_A;
      m_pos[k] = (t > c) ? c + d : c - d;
      if (d != 0) m_changed = 1;
      if (k == 11) begin
        m_settled = !m_changed;
        m_changed = 0;
      end
      m_phase++;
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [95:0] model_pos();
    logic [95:0] p;
    for (int k = 0; k < 12; k++) p[8*k +: 8] = m_pos[k][7:0];
    return p;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_a);
      if (!rst_a) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of instance A against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("model_pos", pos_a, model_pos());
        check("model_busy", busy_a, (m_phase >= TD && m_phase < TD + 12));
        check("model_done", done_a, (m_phase == TD + 12));
        check("model_settled", settled_a, m_settled);
      end
    end
  end

  function automatic logic done_of(input int w);
    if (w == 0) return done_a;
    if (w == 1) return done_b;
    return done_c;
  endfunction

  task automatic wait_done(input int w, input string nm, output int n);
    bit seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = done_of(w);
    end
    if (!seen) check(nm, 96'd0, 96'd1);
  endtask

  task automatic wait_busy(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy_a && n < 300);
    if (!busy_a) check(nm, 96'd0, 96'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bc;
    bit any_busy;
    logic [7:0] vals[4];
    logic [95:0] exp_c;

    tgt_a = {12{8'd25}};
    tgt_b = {12{8'd128}};
    tgt_b[7:0]   = 8'd0;
    tgt_b[47:40] = 8'd255;
    tgt_b[95:88] = 8'd133;
    exp_c = {6{16'hFF00}};
    tgt_c = exp_c;

    repeat (3) @(negedge clk);
    check("rst_pos_a", pos_a, 96'd0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_settled_a", settled_a, 0);
    check("rst_pos_b", pos_b, {12{8'd128}});
    check("rst_pos_c", pos_c, {12{8'd100}});

    // All targets 25 from 0 in steps of 10.
    cmp_en = 1'b1;
    rst_a  = 1'b1;
    vals   = '{8'd10, 8'd20, 8'd25, 8'd25};
    for (int s = 0; s < 4; s++) begin
      wait_done(0, "sweep_done_timeout", n);
      check($sformatf("sweep%0d_pos", s + 1), pos_a, {12{vals[s]}});
      check($sformatf("sweep%0d_settled", s + 1), settled_a, (s == 3));
      if (s > 0) check($sformatf("period%0d", s + 1), n, 17);
    end

    // Asynchronous reset on sweep cycle 6.
    wait_busy("busy_timeout", n);
    repeat (6) @(negedge clk);
    #2 rst_a = 1'b0;
    #1;
    check("async_rst_pos", pos_a, 96'd0);
    check("async_rst_busy", busy_a, 0);
    check("async_rst_settled", settled_a, 0);
    check("async_rst_done", done_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    wait_busy("first_sweep_timeout", n);
    check("first_sweep_after_release", n, TD);
    for (int s = 0; s < 3; s++) wait_done(0, "rebuild_timeout", n);
    check("rebuilt_pos", pos_a, {12{8'd25}});

    // Snapshot isolation: servo 11 target moves on sweep cycle 3.
    wait_busy("busy_timeout", n);
    repeat (3) @(negedge clk);
    tgt_a[95:88] = 8'd200;
    wait_done(0, "snap_done_timeout", n);
    check("snap_old_target", pos_a, {12{8'd25}});
    check("snap_old_settled", settled_a, 1);
    wait_done(0, "snap_done_timeout", n);
    check("snap_new_target", pos_a[95:88], 8'd35);
    check("snap_new_settled", settled_a, 0);

    // Hold during idle count 2 for 10 cycles stretches the period by 10.
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) hold_a = 1'b1;
      if (n == 13) hold_a = 1'b0;
    end while (!done_a && n < 100);
    check("hold_idle_period", n, 27);
    check("hold_idle_pos11", pos_a[95:88], 8'd45);

    // Hold raised mid-sweep: the sweep still completes, the next one is stalled.
    wait_busy("busy_timeout", n);
    bc = 1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 4) hold_a = 1'b1;
      if (busy_a) bc++;
    end while (!done_a && n < 50);
    check("hold_mid_busy_cycles", bc, 12);
    check("hold_mid_done", done_a, 1);
    check("hold_mid_pos11", pos_a[95:88], 8'd55);
    any_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_a) any_busy = 1;
    end
    check("hold_stalls_idle", any_busy, 0);
    hold_a = 1'b0;

    // Mixed directions (B) and full-range steps (C), reset together.
    rst_bc = 1'b1;
    for (int s = 1; s <= 14; s++) begin
      wait_done(1, "b_done_timeout", n);
      if (s == 1) begin
        check("mixed_s1_servo0", pos_b[7:0], 8'd118);
        check("mixed_s1_servo5", pos_b[47:40], 8'd138);
        check("mixed_s1_servo11", pos_b[95:88], 8'd133);
        check("mixed_s1_servo3", pos_b[31:24], 8'd128);
        check("step255_s1_done", done_c, 1);
        check("step255_s1_pos", pos_c, exp_c);
        check("step255_s1_settled", settled_c, 0);
      end
      if (s == 2) check("step255_s2_settled", settled_c, 1);
      if (s == 12) check("mixed_s12_servo0", pos_b[7:0], 8'd8);
      if (s == 13) begin
        check("mixed_s13_servo0", pos_b[7:0], 8'd0);
        check("mixed_s13_servo5", pos_b[47:40], 8'd255);
      end
      if (s == 14) check("mixed_s14_servo0_floor", pos_b[7:0], 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/servo_slew_scheduler.md
# servo_slew_scheduler

Rate-limits the twelve servo position bytes written over SPI so the legs move smoothly rather than jumping to each new target. Sits between the SPI control registers and the twelve PWM generators. It keeps one current position per servo and, once per update period, walks a single shared compare/step datapath round-robin over servos 0..11. Each visit moves that servo's current position toward its target by at most STEP.

## Interface
- TICK_DIV, default 16'd50000: clk cycles spent in IDLE between sweeps; legal range 1..65535.
- STEP, default 8'd2: maximum change of one position per sweep; legal range 1..255.
- INIT_POS, default 8'd0: reset value of every current position.
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- iTarget  input  96  packed targets; servo k at [8k+7:8k]; k=0..11 is TL coxa/femur/tibia, TR c/f/t, BL c/f/t, BR c/f/t.
- iHold  input  1  while high, no new sweep starts; a sweep already in progress completes.
- oPos  output  96  packed current positions, same packing as iTarget; drives the PWM control inputs.
- oBusy  output  1  high while in SWEEP.
- oSweep_Done  output  1  one-cycle pulse in the DONE state.
- oSettled  output  1  high when the last completed sweep changed no position.

## Operation
- States are IDLE, SWEEP and DONE. Reset enters IDLE with the tick counter at 0 and idx at 0.
- IDLE:
  - The tick counter increments each cycle while iHold is low and holds while iHold is high.
  - When the counter equals TICK_DIV-1 and iHold is low, the next state is SWEEP. On that same edge the counter clears and all 96 bits of iTarget are copied into the snapshot register.
- SWEEP: one servo per cycle, idx 0..11. For servo idx, with cur the current position and tgt the snapshot target:
  - If cur == tgt, no change.
  - If tgt > cur and tgt-cur <= STEP, cur <= tgt. If tgt > cur and the gap is larger, cur <= cur+STEP.
  - If tgt < cur and cur-tgt <= STEP, cur <= tgt. If tgt < cur and the gap is larger, cur <= cur-STEP.
  - The difference is computed as unsigned 8-bit magnitude with the sign from the comparison. Results never wrap past 0 or 255.
  - A sticky "changed" flag is set if any servo's value changes during the sweep.
  - After idx 11, the next state is DONE and idx returns to 0.
- DONE: lasts one cycle. oSweep_Done=1 and oSettled <= ~changed; the changed flag clears. The next state is IDLE.
- iTarget changes during SWEEP or DONE have no effect until the next snapshot.
- iHold rising mid-sweep does not stop the sweep. It only stalls IDLE.
- STEP=255 makes every sweep jump straight to the target.

## Timing
- Reset values: oPos = {12{INIT_POS}}, oBusy=0, oSweep_Done=0, oSettled=0, snapshot = {12{INIT_POS}}, changed=0.
- With iHold low, one full period is TICK_DIV (IDLE) + 12 (SWEEP) + 1 (DONE) cycles.
- Servo k's oPos byte updates on the clock edge at the end of SWEEP cycle k. It is visible k+1 cycles after SWEEP entry.
- oBusy is registered and high for exactly 12 cycles per sweep.
- oSweep_Done is high for exactly 1 cycle. oSettled updates on the same edge that raises oSweep_Done.
- After deassertion of rst_n, the first sweep starts TICK_DIV cycles later, provided iHold is low.
- Asserting rst_n mid-sweep returns all state to reset values immediately (asynchronously). Partially updated positions are discarded back to INIT_POS.
- All outputs are registered; there is no combinational path from iTarget or iHold to any output.

## Test plan
- TICK_DIV=4, STEP=10, INIT_POS=0; all targets 25:
  - Sweep 1 gives every byte 10 and oSettled=0. Sweep 2 gives 20, sweep 3 gives 25, sweep 4 leaves 25 with oSettled=1.
  - oSweep_Done pulses every 17 cycles.
- Mixed directions: INIT_POS=128, STEP=10; servo 0 target 0, servo 5 target 255, servo 11 target 133, others 128.
  - After one sweep: 118, 138, 133, 128. Clamp: servo 0 reaches 0 exactly after 13 sweeps and never goes below 0.
- Snapshot isolation: change servo 11's target from 25 to 200 on SWEEP cycle 3.
  - That sweep uses the old value 25. The next sweep steps toward 200.
- iHold: raise iHold during IDLE count 2 and hold it 10 cycles.
  - The counter freezes and SWEEP is delayed by 10 cycles. Raising iHold mid-sweep still yields all 12 updates and the DONE pulse.
- Reset mid-sweep: pull rst_n low on SWEEP cycle 6.
  - oPos returns to all INIT_POS, oBusy=0 and oSettled=0 immediately, without waiting for a clock edge. The first sweep occurs TICK_DIV cycles after release.
- STEP=255: targets 0/255 alternating from INIT_POS=100.
  - All bytes equal their targets after one sweep; the next sweep reports oSettled=1.
